// File: rtl/decimal_to_seven_segment.sv
// rtl/decimal_to_seven_segment.sv - registered BCD to 7-segment decoder with blank, lamp test and polarity
// Lit vector is resolved combinationally, then polarity is applied as it enters the output register.
module decimal_to_seven_segment #(
  parameter bit          ACTIVE_LOW   = 1'b1,
  parameter int unsigned INVALID_MODE = 0
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [3:0] digit,
  input  logic       blank,
  input  logic       lamp_test,
  output logic [6:0] seg
);

  localparam logic [6:0] LIT_NONE = 7'b0000000;
  localparam logic [6:0] LIT_ALL  = 7'b1111111;
  localparam logic [6:0] LIT_DASH = 7'b1000000;

  logic [6:0] lit;

  // Fallback for 10-15 and any unresolvable code; unknown modes read as blank.
  function automatic logic [6:0] invalid_lit(input logic [3:0] code);
    logic [6:0] r;
    r = LIT_NONE;
    if (INVALID_MODE == 1) begin
      case (code)
        4'd10:   r = 7'b1110111;
        4'd11:   r = 7'b1111100;
        4'd12:   r = 7'b0111001;
        4'd13:   r = 7'b1011110;
        4'd14:   r = 7'b1111001;
        4'd15:   r = 7'b1110001;
        default: r = LIT_NONE;
      endcase
    end else if (INVALID_MODE == 2) begin
      r = LIT_DASH;
    end
    return r;
  endfunction

  always_comb begin
    lit = LIT_NONE;
    if (lamp_test) begin
      lit = LIT_ALL;
    end else if (blank) begin
      lit = LIT_NONE;
    end else begin
      case (digit)
        4'd0:    lit = 7'b0111111;
        4'd1:    lit = 7'b0000110;
        4'd2:    lit = 7'b1011011;
        4'd3:    lit = 7'b1001111;
        4'd4:    lit = 7'b1100110;
        4'd5:    lit = 7'b1101101;
        4'd6:    lit = 7'b1111101;
        4'd7:    lit = 7'b0000111;
        4'd8:    lit = 7'b1111111;
        4'd9:    lit = 7'b1101111;
        default: lit = invalid_lit(digit);
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      seg <= ACTIVE_LOW ? ~LIT_NONE : LIT_NONE;
    end else begin
      seg <= ACTIVE_LOW ? ~lit : lit;
    end
  end

endmodule

// File: tb/tb_decimal_to_seven_segment.sv
// tb/tb_decimal_to_seven_segment.sv - self-checking bench for decimal_to_seven_segment
// Five variants share one stimulus; a glyph-level model predicts every output each cycle.
module tb_decimal_to_seven_segment;

  logic       clk;
  logic       reset;
  logic [3:0] digit;
  logic       blank;
  logic       lamp_test;
  logic [6:0] seg0, seg1, seg2, seg3, seg4;

  int n_checks = 0;
  int n_fail   = 0;

  localparam int NI = 5;
  localparam int AL_TAB [NI] = '{1, 1, 1, 0, 1};
  localparam int IM_TAB [NI] = '{0, 1, 2, 1, 3};

  decimal_to_seven_segment #(.ACTIVE_LOW(1'b1), .INVALID_MODE(0)) u0 (
    .CLOCK_50(clk), .reset(reset), .digit(digit), .blank(blank), .lamp_test(lamp_test), .seg(seg0));
  decimal_to_seven_segment #(.ACTIVE_LOW(1'b1), .INVALID_MODE(1)) u1 (
    .CLOCK_50(clk), .reset(reset), .digit(digit), .blank(blank), .lamp_test(lamp_test), .seg(seg1));
  decimal_to_seven_segment #(.ACTIVE_LOW(1'b1), .INVALID_MODE(2)) u2 (
    .CLOCK_50(clk), .reset(reset), .digit(digit), .blank(blank), .lamp_test(lamp_test), .seg(seg2));
  decimal_to_seven_segment #(.ACTIVE_LOW(1'b0), .INVALID_MODE(1)) u3 (
    .CLOCK_50(clk), .reset(reset), .digit(digit), .blank(blank), .lamp_test(lamp_test), .seg(seg3));
  decimal_to_seven_segment #(.ACTIVE_LOW(1'b1), .INVALID_MODE(3)) u4 (
    .CLOCK_50(clk), .reset(reset), .digit(digit), .blank(blank), .lamp_test(lamp_test), .seg(seg4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] dut_seg(input int i);
    case (i)
      0: return seg0;
      1: return seg1;
      2: return seg2;
      3: return seg3;
      default: return seg4;
    endcase
  endfunction

  // Glyphs as the set of lit segment letters.
  function automatic string glyph(input int d, input int mode);
    string dec [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                        "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};
    string hex [6]  = '{"abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};
    if (d < 10) return dec[d];
    if (mode == 1) return hex[d - 10];
    if (mode == 2) return "g";
    return "";
  endfunction

  function automatic logic [6:0] letters_to_lit(input string s);
    logic [6:0] v;
    v = '0;
    for (int k = 0; k < s.len(); k++) v[s[k] - "a"] = 1'b1;
    return v;
  endfunction

  logic [6:0] expect_seg [NI];
  bit         model_valid = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      logic [6:0] l;
      if (reset)          l = '0;
      else if (lamp_test) l = '1;
      else if (blank)     l = '0;
      else                l = letters_to_lit(glyph(int'(digit), IM_TAB[i]));
      expect_seg[i] = (AL_TAB[i] == 1) ? ~l : l;
    end
    model_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (model_valid) begin
      for (int i = 0; i < NI; i++) begin
        n_checks++;
        if (dut_seg(i) !== expect_seg[i]) begin
          n_fail++;
          $display("FAIL model_u%0d t=%0t got=%b exp=%b", i, $time, dut_seg(i), expect_seg[i]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [6:0] got, input logic [6:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  initial begin
    reset = 1'b1; digit = 4'd8; blank = 1'b0; lamp_test = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_al1", seg0, 7'b1111111);
    chk("reset_al0", seg3, 7'b0000000);

    reset = 1'b0;
    @(negedge clk);
    chk("release_8", seg0, 7'b0000000);

    for (int d = 0; d < 10; d++) begin
      digit = 4'(d);
      @(negedge clk);
      if (d == 3) chk("dec_3", seg0, 7'b0110000);
      if (d == 7) chk("dec_7", seg0, 7'b1111000);
      if (d == 0) chk("dec_0", seg0, 7'b1000000);
    end

    for (int d = 10; d < 16; d++) begin
      digit = 4'(d);
      @(negedge clk);
      chk("inv_mode0", seg0, 7'b1111111);
      chk("inv_mode2", seg2, 7'b0111111);
      chk("inv_mode3", seg4, 7'b1111111);
      if (d == 10) chk("hex_A", seg1, 7'b0001000);
      if (d == 15) chk("hex_F", seg1, 7'b0001110);
    end

    digit = 4'd5; blank = 1'b1;
    @(negedge clk);
    chk("blank", seg0, 7'b1111111);
    lamp_test = 1'b1;
    @(negedge clk);
    chk("lamp_over_blank", seg0, 7'b0000000);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_over_lamp", seg0, 7'b1111111);

    reset = 1'b0; lamp_test = 1'b0; blank = 1'b0; digit = 4'd1;
    @(negedge clk);
    chk("pol_al0_1", seg3, 7'b0000110);
    reset = 1'b1;
    @(negedge clk);
    chk("pol_al0_reset", seg3, 7'b0000000);
    reset = 1'b0;

    digit = 4'd2;
    @(negedge clk);
    chk("lat_2", seg0, 7'b0100100);
    digit = 4'd9;
    #1 chk("lat_hold_2", seg0, 7'b0100100);
    @(negedge clk);
    chk("lat_9", seg0, 7'b0010000);
    digit = 4'd2;
    #1 chk("lat_hold_9", seg0, 7'b0010000);
    @(negedge clk);
    chk("lat_2b", seg0, 7'b0100100);

    for (int n = 0; n < 60; n++) begin
      digit     = 4'($urandom_range(0, 15));
      blank     = ($urandom_range(0, 7) == 0);
      lamp_test = ($urandom_range(0, 9) == 0);
      reset     = ($urandom_range(0, 15) == 0);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
